// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control bundle between the multicycle controller and its datapath
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_we;
  logic       ir_we;
  logic [1:0] npc_sel;
  logic [1:0] ext_op;
  logic [2:0] alu_op;
  logic       alu_src_b;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic       mem_we;
  logic       instr_done;
  logic [2:0] state;

  // Controller side: reads instruction fields and flags, drives every control line.
  modport master (
    input  opcode, funct, zero,
    output pc_we, ir_we, npc_sel, ext_op, alu_op, alu_src_b,
    output reg_we, reg_dst, wd_sel, mem_we, instr_done, state
  );

  // Datapath side: the mirror image.
  modport slave (
    output opcode, funct, zero,
    input  pc_we, ir_we, npc_sel, ext_op, alu_op, alu_src_b,
    input  reg_we, reg_dst, wd_sel, mem_we, instr_done, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS-subset controller FSM; MC_CTRL_ILLEGAL_TRAP_EN traps undecoded instructions into HALT
module mc_ctrl (
  input  logic     clk,
  input  logic     reset,
  mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic is_r, is_addu, is_subu, is_jr, is_nop;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_illegal;
  logic [1:0] ext_sel;

  // Instruction class decode from the IR fields; an all-zero R-type word is nop.
  always_comb begin
    is_r       = (bus.opcode == 6'b000000);
    is_addu    = is_r && (bus.funct == 6'b100001);
    is_subu    = is_r && (bus.funct == 6'b100011);
    is_jr      = is_r && (bus.funct == 6'b001000);
    is_nop     = is_r && (bus.funct == 6'b000000);
    is_ori     = (bus.opcode == 6'b001101);
    is_lui     = (bus.opcode == 6'b001111);
    is_lw      = (bus.opcode == 6'b100011);
    is_sw      = (bus.opcode == 6'b101011);
    is_beq     = (bus.opcode == 6'b000100);
    is_j       = (bus.opcode == 6'b000010);
    is_jal     = (bus.opcode == 6'b000011);
    is_illegal = !(is_addu || is_subu || is_jr || is_nop || is_ori || is_lui ||
                   is_lw || is_sw || is_beq || is_j || is_jal);
    if (is_ori)      ext_sel = 2'b01;
    else if (is_lui) ext_sel = 2'b10;
    else             ext_sel = 2'b00;
  end

  // Next-state and control outputs; everything is forced quiet while reset is high.
  always_comb begin
    state_d        = state_q;
    bus.pc_we      = 1'b0;
    bus.ir_we      = 1'b0;
    bus.npc_sel    = 2'b00;
    bus.ext_op     = 2'b00;
    bus.alu_op     = 3'b000;
    bus.alu_src_b  = 1'b0;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 2'b00;
    bus.wd_sel     = 2'b00;
    bus.mem_we     = 1'b0;
    bus.instr_done = 1'b0;

    case (state_q)
      FETCH: begin
        bus.ir_we = 1'b1;
        bus.pc_we = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        bus.ext_op = ext_sel;
        if (is_illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_d = HALT;
`else
          bus.instr_done = 1'b1;
          state_d        = FETCH;
`endif
        end else if (is_j || is_jal) begin
          bus.pc_we      = 1'b1;
          bus.npc_sel    = 2'b01;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
          if (is_jal) begin
            bus.reg_we  = 1'b1;
            bus.reg_dst = 2'b10;
            bus.wd_sel  = 2'b10;
          end
        end else if (is_jr) begin
          bus.pc_we      = 1'b1;
          bus.npc_sel    = 2'b10;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end else if (is_nop) begin
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        bus.ext_op = ext_sel;
        if (is_subu || is_beq)     bus.alu_op = 3'b001;
        else if (is_ori || is_lui) bus.alu_op = 3'b010;
        else                       bus.alu_op = 3'b000;
        bus.alu_src_b = is_ori || is_lui || is_lw || is_sw;
        if (is_beq) begin
          bus.pc_we      = bus.zero;
          bus.npc_sel    = 2'b11;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end else if (is_lw || is_sw) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        bus.ext_op = ext_sel;
        if (is_sw) begin
          bus.mem_we     = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        bus.ext_op     = ext_sel;
        bus.reg_we     = 1'b1;
        bus.reg_dst    = is_r ? 2'b01 : 2'b00;
        bus.wd_sel     = is_lw ? 2'b01 : 2'b00;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (reset) begin
      bus.pc_we      = 1'b0;
      bus.ir_we      = 1'b0;
      bus.npc_sel    = 2'b00;
      bus.ext_op     = 2'b00;
      bus.alu_op     = 3'b000;
      bus.alu_src_b  = 1'b0;
      bus.reg_we     = 1'b0;
      bus.reg_dst    = 2'b00;
      bus.wd_sel     = 2'b00;
      bus.mem_we     = 1'b0;
      bus.instr_done = 1'b0;
    end
  end

  // State register; reset lands in FETCH without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl with per-cycle expected control vectors
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic reset;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we;
    logic       ir_we;
    logic [1:0] npc;
    logic [1:0] ext;
    logic [2:0] alu;
    logic       srcb;
    logic       rwe;
    logic [1:0] rdst;
    logic [1:0] wd;
    logic       mwe;
    logic       done;
  } vec_t;

  vec_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic vec_t v(input logic [2:0] st, input logic pc, input logic ir,
                             input logic [1:0] npc, input logic [1:0] ext,
                             input logic [2:0] alu, input logic srcb, input logic rwe,
                             input logic [1:0] rdst, input logic [1:0] wd,
                             input logic mwe, input logic done);
    vec_t r;
    r = '{st, pc, ir, npc, ext, alu, srcb, rwe, rdst, wd, mwe, done};
    return r;
  endfunction

  function automatic vec_t sample();
    vec_t r;
    r = '{bus.state, bus.pc_we, bus.ir_we, bus.npc_sel, bus.ext_op, bus.alu_op,
          bus.alu_src_b, bus.reg_we, bus.reg_dst, bus.wd_sel, bus.mem_we, bus.instr_done};
    return r;
  endfunction

  task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                  name, act, act.st, exp, exp.st);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every cycle that has an expectation queued is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk_vec(t, sample(), e);
    end
  end

  task automatic push(input string tag, input vec_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called one time unit after a rising edge at the start of a FETCH cycle.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int n,
                           input vec_t e1, input vec_t e2, input vec_t e3, input vec_t e4);
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    push({tag, "_fetch"}, v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (n > 1) push({tag, "_c1"}, e1);
    if (n > 2) push({tag, "_c2"}, e2);
    if (n > 3) push({tag, "_c3"}, e3);
    if (n > 4) push({tag, "_c4"}, e4);
    step(n);
  endtask

  vec_t zv;
  vec_t dq;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    zv = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dq = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset      = 1'b1;
    bus.opcode = 6'd0;
    bus.funct  = 6'd0;
    bus.zero   = 1'b0;
    #2;
    chk_vec("reset_async_initial", sample(), zv);
    step(2);
    chk_vec("reset_held", sample(), zv);
    reset = 1'b0;

    // ori: ext_op=01 from DECODE to WB, register write only in WB
    run_instr("ori", 6'b001101, 6'd0, 1'b0, 4,
              v(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0),
              v(2, 0, 0, 0, 1, 3'b010, 1, 0, 0, 0, 0, 0),
              v(4, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1), zv);
    // lw: five cycles, memory data written back
    run_instr("lw", 6'b100011, 6'd0, 1'b0, 5,
              dq,
              v(2, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 0),
              v(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              v(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    // sw: single-cycle memory write
    run_instr("sw", 6'b101011, 6'd0, 1'b0, 4,
              dq,
              v(2, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 0),
              v(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), zv);
    // beq taken and not taken
    run_instr("beq_z1", 6'b000100, 6'd0, 1'b1, 3,
              dq, v(2, 1, 0, 3, 0, 3'b001, 0, 0, 0, 0, 0, 1), zv, zv);
    run_instr("beq_z0", 6'b000100, 6'd0, 1'b0, 3,
              dq, v(2, 0, 0, 3, 0, 3'b001, 0, 0, 0, 0, 0, 1), zv, zv);
    // jumps
    run_instr("jal", 6'b000011, 6'd0, 1'b0, 2,
              v(1, 1, 0, 1, 0, 0, 0, 1, 2, 2, 0, 1), zv, zv, zv);
    run_instr("j", 6'b000010, 6'd0, 1'b0, 2,
              v(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), zv, zv, zv);
    run_instr("jr", 6'b000000, 6'b001000, 1'b0, 2,
              v(1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1), zv, zv, zv);
    // lui: upper-immediate extension
    run_instr("lui", 6'b001111, 6'd0, 1'b0, 4,
              v(1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0),
              v(2, 0, 0, 0, 2, 3'b010, 1, 0, 0, 0, 0, 0),
              v(4, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 1), zv);
    // R-type arithmetic writes rd
    run_instr("addu", 6'b000000, 6'b100001, 1'b1, 4,
              dq,
              v(2, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0),
              v(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1), zv);
    run_instr("subu", 6'b000000, 6'b100011, 1'b0, 4,
              dq,
              v(2, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0),
              v(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1), zv);
    run_instr("nop", 6'b000000, 6'b000000, 1'b0, 2,
              v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), zv, zv, zv);

    // Asynchronous reset during the MEM cycle of sw
    bus.opcode = 6'b101011;
    bus.funct  = 6'd0;
    push("swr_fetch", v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("swr_decode", dq);
    push("swr_exec", v(2, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 0));
    step(3);
    chk("swr_in_mem_state", {5'd0, bus.state}, 8'd3);
    chk("swr_in_mem_we", {7'd0, bus.mem_we}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("swr_async_state", {5'd0, bus.state}, 8'd0);
    chk("swr_async_mem_we", {7'd0, bus.mem_we}, 8'd0);
    chk_vec("swr_async_all", sample(), zv);
    step(1);
    chk_vec("swr_reset_held", sample(), zv);
    reset = 1'b0;

    // First instruction after reset release starts with FETCH immediately
    run_instr("post_reset_ori", 6'b001101, 6'd0, 1'b0, 4,
              v(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0),
              v(2, 0, 0, 0, 1, 3'b010, 1, 0, 0, 0, 0, 0),
              v(4, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1), zv);

    // Undecoded opcode
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    bus.opcode = 6'b111111;
    bus.funct  = 6'd0;
    push("ill_fetch", v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("ill_decode", dq);
    for (int i = 0; i < 10; i++) push("ill_halt", v(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(12);
    reset = 1'b1;
    #1;
    chk_vec("ill_reset_exit", sample(), zv);
    step(1);
    reset = 1'b0;
`else
    run_instr("ill_as_nop", 6'b111111, 6'd0, 1'b0, 2,
              v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), zv, zv, zv);
`endif
    run_instr("final_j", 6'b000010, 6'd0, 1'b0, 2,
              v(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), zv, zv, zv);

    step(2);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
